brick_fall_ctrl: RTL and testbench

//  Consumes the brick-fall tick (tombeeBrique) from the time base and runs one falling brick.

---
 rtl/brick_fall_ctrl.sv | 176 +++++++++++++++++
 tb/tb_brick_fall_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_fall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : brick_fall_ctrl
//  Description : Runs one falling brick at a time. The brick spawns at an
//                LFSR-chosen column, drops one row per enabled tick, and is
//                checked against the paddle on the bottom row. A catch adds
//                to a saturating score. A miss costs a life and can end the
//                game.
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_fall_ctrl #(
    parameter int          COLS      = 8,
    parameter int          ROWS      = 16,
    parameter int          X_W       = 3,
    parameter int          Y_W       = 4,
    parameter int          PADDLE_W  = 2,
    parameter int          LIVES     = 3,
    parameter int          SCORE_W   = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    input  logic               i_tick,
    input  logic               i_start,
    input  logic [X_W-1:0]     i_paddle_x,
    output logic [X_W-1:0]     o_brick_x,
    output logic [Y_W-1:0]     o_brick_y,
    output logic               o_brick_active,
    output logic               o_caught,
    output logic               o_missed,
    output logic [SCORE_W-1:0] o_score,
    output logic [2:0]         o_lives,
    output logic               o_game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [X_W-1:0]     c_X_MASK    = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]     c_Y_LAST    = Y_W'(ROWS - 1);
    localparam logic [X_W:0]       c_PADDLE_W  = (X_W + 1)'(PADDLE_W);
    localparam logic [2:0]         c_LIVES     = 3'(LIVES);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

    state_t               r_state;
    state_t               w_next_state;
    logic [7:0]           r_lfsr;
    logic [X_W-1:0]       r_brick_x;
    logic [Y_W-1:0]       r_brick_y;
    logic                 r_brick_active;
    logic                 r_caught;
    logic                 r_missed;
    logic [SCORE_W-1:0]   r_score;
    logic [2:0]           r_lives;
    logic                 r_game_over;

    logic                 w_lfsr_fb;
    logic                 w_fall_tick;
    logic [X_W:0]         w_bx_ext;
    logic [X_W:0]         w_px_ext;
    logic [X_W:0]         w_px_end;
    logic                 w_hit;
    logic [2:0]           w_lives_dec;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_fall_tick = i_tick & i_enable;

    // One extra bit so a paddle at the right edge does not wrap to column 0
    assign w_bx_ext    = {1'b0, r_brick_x};
    assign w_px_ext    = {1'b0, i_paddle_x};
    assign w_px_end    = w_px_ext + c_PADDLE_W;
    assign w_hit       = (w_bx_ext >= w_px_ext) && (w_bx_ext < w_px_end);
    assign w_lives_dec = r_lives - 3'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_SPAWN;
            S_SPAWN: w_next_state = S_FALL;
            S_FALL:  if (w_fall_tick && (r_brick_y == c_Y_LAST)) w_next_state = S_CHECK;
            S_CHECK: begin
                if (!w_hit && (w_lives_dec == 3'd0)) begin
                    w_next_state = S_OVER;
                end else begin
                    w_next_state = S_SPAWN;
                end
            end
            S_OVER:  if (i_start) w_next_state = S_SPAWN;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Brick position, score, lives and LFSR updates; caught/missed default low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr         <= LFSR_SEED;
            r_brick_x      <= '0;
            r_brick_y      <= '0;
            r_brick_active <= 1'b0;
            r_caught       <= 1'b0;
            r_missed       <= 1'b0;
            r_score        <= '0;
            r_lives        <= c_LIVES;
            r_game_over    <= 1'b0;
        end else begin
            r_caught <= 1'b0;
            r_missed <= 1'b0;
            case (r_state)
                S_SPAWN: begin
                    r_brick_x      <= r_lfsr[X_W-1:0] & c_X_MASK;
                    r_brick_y      <= '0;
                    r_brick_active <= 1'b1;
                    r_lfsr         <= {r_lfsr[6:0], w_lfsr_fb};
                end
                S_FALL: begin
                    if (w_fall_tick && (r_brick_y != c_Y_LAST)) begin
                        r_brick_y <= r_brick_y + Y_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_caught <= 1'b1;
                        if (r_score != c_SCORE_MAX) begin
                            r_score <= r_score + SCORE_W'(1);
                        end
                    end else begin
                        r_missed       <= 1'b1;
                        r_lives        <= w_lives_dec;
                        r_brick_active <= 1'b0;
                        if (w_lives_dec == 3'd0) begin
                            r_game_over <= 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (i_start) begin
                        r_score     <= '0;
                        r_lives     <= c_LIVES;
                        r_game_over <= 1'b0;
                        r_lfsr      <= LFSR_SEED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_brick_x      = r_brick_x;
    assign o_brick_y      = r_brick_y;
    assign o_brick_active = r_brick_active;
    assign o_caught       = r_caught;
    assign o_missed       = r_missed;
    assign o_score        = r_score;
    assign o_lives        = r_lives;
    assign o_game_over    = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_brick_fall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brick_fall_ctrl
//  Description : Self-checking bench for brick_fall_ctrl with an expected-
//                result queue fed by a small game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_fall_ctrl;

    typedef struct {
        logic [2:0] x;
        logic [3:0] y;
        logic       act;
        logic       cau;
        logic       mis;
        logic [7:0] score;
        logic [2:0] lives;
        logic       go;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       tick;
    logic       start;
    logic [2:0] paddle_x;
    logic [2:0] brick_x;
    logic [3:0] brick_y;
    logic       brick_active;
    logic       caught;
    logic       missed;
    logic [7:0] score;
    logic [2:0] lives;
    logic       game_over;

    int         n_cmp;
    int         n_err;
    exp_t       sb_q[$];

    logic [7:0] m_lfsr;
    logic [2:0] m_x;
    int         m_score;
    int         m_lives;

    brick_fall_ctrl u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (enable),
        .i_tick         (tick),
        .i_start        (start),
        .i_paddle_x     (paddle_x),
        .o_brick_x      (brick_x),
        .o_brick_y      (brick_y),
        .o_brick_active (brick_active),
        .o_caught       (caught),
        .o_missed       (missed),
        .o_score        (score),
        .o_lives        (lives),
        .o_game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic exp_t mk(input logic [2:0] x, input logic [3:0] y, input logic act,
                                input logic cau, input logic mis, input int sc,
                                input int lv, input logic go);
        exp_t e;
        e.x = x; e.y = y; e.act = act; e.cau = cau; e.mis = mis;
        e.score = 8'(sc); e.lives = 3'(lv); e.go = go;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, ".sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, ".x"},      brick_x,      e.x);
            chk({tag, ".y"},      brick_y,      e.y);
            chk({tag, ".active"}, brick_active, e.act);
            chk({tag, ".caught"}, caught,       e.cau);
            chk({tag, ".missed"}, missed,       e.mis);
            chk({tag, ".score"},  score,        e.score);
            chk({tag, ".lives"},  lives,        e.lives);
            chk({tag, ".over"},   game_over,    e.go);
        end
    endtask

    task automatic push_spawn();
        m_x    = m_lfsr[2:0];
        m_lfsr = lfsr_next(m_lfsr);
        sb_q.push_back(mk(m_x, 4'd0, 1'b1, 1'b0, 1'b0, m_score, m_lives, 1'b0));
    endtask

    task automatic start_game(input string tag);
        m_lfsr  = 8'hA5;
        m_score = 0;
        m_lives = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        push_spawn();
        step();
        sb_check(tag);
    endtask

    // Drop the current brick to the bottom and land it against paddle column pad
    task automatic drop(input logic [2:0] pad, input string tag);
        bit hit;
        bit seen;
        paddle_x = pad;
        repeat (15) do_tick();
        chk({tag, ".y15"}, brick_y, 15);
        hit = (int'(m_x) >= int'(pad)) && (int'(m_x) < int'(pad) + 2);
        if (hit) begin
            m_score = (m_score == 255) ? 255 : m_score + 1;
        end else begin
            m_lives = m_lives - 1;
        end
        sb_q.push_back(mk(m_x, 4'd15, hit, hit, !hit, m_score, m_lives, m_lives == 0));
        tick = 1'b1;
        step();
        tick = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (caught || missed) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk({tag, ".land_timeout"}, 0, 1);
            void'(sb_q.pop_front());
        end else begin
            sb_check({tag, ".land"});
            step();
            if (m_lives != 0) begin
                push_spawn();
            end else begin
                sb_q.push_back(mk(m_x, 4'd15, 1'b0, 1'b0, 1'b0, m_score, 0, 1'b1));
            end
            sb_check({tag, ".after"});
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        tick     = 1'b0;
        start    = 1'b0;
        paddle_x = 3'd0;
        m_lfsr   = 8'hA5;
        m_x      = 3'd0;
        m_score  = 0;
        m_lives  = 3;

        repeat (3) step();
        sb_q.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0));
        sb_check("reset");
        reset = 1'b0;
        step();

        // First brick spawns at A5[2:0] = 5
        start_game("start1");
        chk("start1.x_is_5", brick_x, 5);

        drop(3'd4, "catch1");
        drop((m_x >= 3'd2) ? 3'd0 : 3'd4, "miss1");
        drop((m_x >= 3'd2) ? 3'd0 : 3'd4, "miss2");
        drop((m_x >= 3'd2) ? 3'd0 : 3'd4, "miss3");

        // Game over: ticks and paddle changes must not disturb anything
        paddle_x = 3'd3;
        repeat (5) do_tick();
        sb_q.push_back(mk(m_x, 4'd15, 1'b0, 1'b0, 1'b0, m_score, 0, 1'b1));
        sb_check("over_hold");

        start_game("restart");
        chk("restart.x_is_5", brick_x, 5);

        // Catch until the score saturates; one x=0 brick is aimed at paddle 7 to miss
        begin
            bit did_miss0;
            int pre;
            did_miss0 = 1'b0;
            for (int b = 0; b < 400; b++) begin
                pre = m_score;
                if (m_x == 3'd0 && !did_miss0) begin
                    did_miss0 = 1'b1;
                    drop(3'd7, "edge_x0_p7");
                end else if (m_x == 3'd7) begin
                    drop(3'd7, "edge_x7_p7");
                end else begin
                    drop(m_x, "catch_run");
                end
                if (pre == 255 && m_score == 255 && caught === 1'b0 && brick_y == 4'd0) begin
                    break;
                end
            end
            chk("sat.score", score, 255);
        end

        // Pause mid-fall: ticks and start are ignored while disabled
        paddle_x = 3'd0;
        repeat (5) do_tick();
        chk("pause.y_before", brick_y, 5);
        enable = 1'b0;
        repeat (10) do_tick();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pause.y_frozen", brick_y, 5);
        chk("pause.x_frozen", brick_x, m_x);
        enable = 1'b1;
        do_tick();
        chk("resume.y", brick_y, 6);

        // Asynchronous reset mid-fall takes effect before the next clock edge
        reset = 1'b1;
        #1;
        sb_q.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0));
        sb_check("async_reset");
        step();
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
